// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types for the EX->MEM pipeline register.
//   ex_mem_ctrl_t   : control bits travelling with each bundle
//   ex_mem_bundle_t : full bundle layout at the default core widths
//   ex_mem_state_t  : occupancy state of the stage (EMPTY / MAIN / FULL)
// The top module packs the bundle into a flat vector sized from its own
// parameters. The packed field order matches ex_mem_bundle_t.
package ex_mem_pkg;

  localparam int CTRL_W = 5;

  // Bit positions inside the 5-bit control word {reg_wr, rd_src, dm2reg, dm_rd, dm_wr}
  localparam int CTRL_REG_WR = 4;
  localparam int CTRL_RD_SRC = 3;
  localparam int CTRL_DM2REG = 2;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_TYPE_W = 3;

  typedef struct packed {
    logic reg_wr;
    logic rd_src;
    logic dm2reg;
    logic dm_rd;
    logic dm_wr;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [DEF_TYPE_W-1:0] datatype;
    logic [DEF_DATA_W-1:0] aluout;
    logic [DEF_DATA_W-1:0] dm_data;
    logic [DEF_ADDR_W-1:0] pc2reg;
    logic [DEF_REG_W-1:0]  rd_addr;
    ex_mem_ctrl_t          ctrl;
  } ex_mem_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } ex_mem_state_t;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// ex_mem_skid_buf: generic payload holding register for the skid entry.
//   clk, rstn : clock, asynchronous active-low reset (payload resets to 0)
//   load      : capture d on the next rising edge
//   d         : incoming payload
//   q         : held payload
// Occupancy (skid valid) is tracked by the owning stage, not here.
module ex_mem_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX->MEM pipeline register with a 1-entry skid buffer.
//   clk, rstn          : core clock, asynchronous active-low reset
//   flush              : drop every held bundle (mispredict / trap)
//   s_valid/s_ready    : EX-side handshake; s_* carry the bundle from EX
//   m_valid/m_ready    : MEM-side handshake; m_* carry the registered bundle
//   fwd_en/fwd_rd_addr/fwd_data : forwarding tap from the main register
//   load_use           : main register holds a load with a non-zero destination
//   dbg_state          : current occupancy state (ex_mem_state_t encoding)
//
// Handshake: a bundle moves when valid and ready are both high at a rising
// edge. A producer keeps valid and payload steady until it is accepted. With
// the skid present, s_ready comes straight from the state flop and never
// looks at m_ready. Without the skid, s_ready = !m_valid | m_ready.
module ex_mem_pipe_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int TYPE_W  = 3,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [TYPE_W-1:0] s_datatype,
  input  logic [DATA_W-1:0] s_aluout,
  input  logic [DATA_W-1:0] s_dm_data,
  input  logic [ADDR_W-1:0] s_pc2reg,
  input  logic [REG_W-1:0]  s_rd_addr,
  input  logic [CTRL_W-1:0] s_ctrl,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [TYPE_W-1:0] m_datatype,
  output logic [DATA_W-1:0] m_aluout,
  output logic [DATA_W-1:0] m_dm_data,
  output logic [ADDR_W-1:0] m_pc2reg,
  output logic [REG_W-1:0]  m_rd_addr,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_rd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_use,
  output logic [1:0]        dbg_state
);

  localparam int PAY_W = TYPE_W + 2 * DATA_W + ADDR_W + REG_W + CTRL_W;

  ex_mem_state_t    state_q, state_d;
  logic [PAY_W-1:0] s_pay, main_q, skid_q;
  logic             in_fire, out_fire;
  logic             main_load, main_sel_skid, skid_load;

  assign s_pay    = {s_datatype, s_aluout, s_dm_data, s_pc2reg, s_rd_addr, s_ctrl};
  assign m_valid  = (state_q != ST_EMPTY);
  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;

  generate
    if (SKID_EN != 0) begin : g_ready_reg
      assign s_ready = (state_q != ST_FULL);
    end else begin : g_ready_comb
      assign s_ready = !m_valid || m_ready;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_MAIN;
          main_load = 1'b1;
        end
      end
      ST_MAIN: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire && (SKID_EN != 0)) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // The older skid entry always reaches main before anything newer.
        if (out_fire) begin
          state_d       = ST_MAIN;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over a simultaneous accept. Payload registers keep their
    // contents, but no new bundle is captured.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
    end else if (main_load) begin
      main_q <= main_sel_skid ? skid_q : s_pay;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      ex_mem_skid_buf #(.WIDTH(PAY_W)) u_skid (
        .clk  (clk),
        .rstn (rstn),
        .load (skid_load),
        .d    (s_pay),
        .q    (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  assign {m_datatype, m_aluout, m_dm_data, m_pc2reg, m_rd_addr, m_ctrl} = main_q;
  assign dbg_state = state_q;

  // The link value is zero-extended or truncated to the data width.
  logic [DATA_W-1:0] pc_fit;
  generate
    if (ADDR_W >= DATA_W) begin : g_pc_trunc
      assign pc_fit = m_pc2reg[DATA_W-1:0];
    end else begin : g_pc_zext
      assign pc_fit = {{(DATA_W - ADDR_W){1'b0}}, m_pc2reg};
    end
  endgenerate

  // x0 never forwards and never causes a load-use stall. The bundle itself
  // still passes through unchanged.
  assign fwd_en      = m_valid && m_ctrl[CTRL_REG_WR] && (m_rd_addr != '0) && !m_ctrl[CTRL_DM2REG];
  assign load_use    = m_valid && m_ctrl[CTRL_DM2REG] && (m_rd_addr != '0);
  assign fwd_rd_addr = m_rd_addr;
  assign fwd_data    = m_ctrl[CTRL_RD_SRC] ? pc_fit : m_aluout;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage. Instance 0 has the skid entry and instance 1
// does not. Inputs change just after the falling edge. Outputs are sampled
// before the next rising edge.
module tb_ex_mem_pipe_stage;
  import ex_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int TW = 3;
  localparam int BW = TW + 2 * DW + AW + RW + CTRL_W;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          flush[2], s_valid[2], s_ready[2], m_valid[2], m_ready[2];
  logic          fwd_en[2], load_use[2];
  logic [TW-1:0] s_datatype[2], m_datatype[2];
  logic [DW-1:0] s_aluout[2], m_aluout[2], s_dm_data[2], m_dm_data[2], fwd_data[2];
  logic [AW-1:0] s_pc2reg[2], m_pc2reg[2];
  logic [RW-1:0] s_rd_addr[2], m_rd_addr[2], fwd_rd_addr[2];
  logic [4:0]    s_ctrl[2], m_ctrl[2];
  logic [1:0]    dbg_state[2];

  int checks = 0;
  int failures = 0;

  ex_mem_pipe_stage #(.SKID_EN(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_datatype(s_datatype[0]), .s_aluout(s_aluout[0]), .s_dm_data(s_dm_data[0]),
    .s_pc2reg(s_pc2reg[0]), .s_rd_addr(s_rd_addr[0]), .s_ctrl(s_ctrl[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_datatype(m_datatype[0]), .m_aluout(m_aluout[0]), .m_dm_data(m_dm_data[0]),
    .m_pc2reg(m_pc2reg[0]), .m_rd_addr(m_rd_addr[0]), .m_ctrl(m_ctrl[0]),
    .fwd_en(fwd_en[0]), .fwd_rd_addr(fwd_rd_addr[0]), .fwd_data(fwd_data[0]),
    .load_use(load_use[0]), .dbg_state(dbg_state[0])
  );

  ex_mem_pipe_stage #(.SKID_EN(0)) dut_ns (
    .clk(clk), .rstn(rstn), .flush(flush[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_datatype(s_datatype[1]), .s_aluout(s_aluout[1]), .s_dm_data(s_dm_data[1]),
    .s_pc2reg(s_pc2reg[1]), .s_rd_addr(s_rd_addr[1]), .s_ctrl(s_ctrl[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_datatype(m_datatype[1]), .m_aluout(m_aluout[1]), .m_dm_data(m_dm_data[1]),
    .m_pc2reg(m_pc2reg[1]), .m_rd_addr(m_rd_addr[1]), .m_ctrl(m_ctrl[1]),
    .fwd_en(fwd_en[1]), .fwd_rd_addr(fwd_rd_addr[1]), .fwd_data(fwd_data[1]),
    .load_use(load_use[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- driver tasks ----------------
  function automatic logic [BW-1:0] mk(input logic [31:0] alu, input logic [4:0] ctrl,
                                       input logic [4:0] rd, input logic [31:0] pc);
    return {3'd2, alu, ~alu, pc, rd, ctrl};
  endfunction

  function automatic logic [BW-1:0] m_bundle(input int b);
    return {m_datatype[b], m_aluout[b], m_dm_data[b], m_pc2reg[b], m_rd_addr[b], m_ctrl[b]};
  endfunction

  task automatic set_in(input int b, input logic v, input logic [BW-1:0] bun);
    s_valid[b] = v;
    {s_datatype[b], s_aluout[b], s_dm_data[b], s_pc2reg[b], s_rd_addr[b], s_ctrl[b]} = bun;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int b = 0; b < 2; b++) begin
      set_in(b, 1'b0, '0);
      m_ready[b] = 1'b0;
      flush[b]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(input int b);
    do_reset();
    checks++; if (m_valid[b] !== 1'b0) begin failures++; $display("FAIL reset_m_valid b=%0d got=%b exp=0", b, m_valid[b]); end
    checks++; if (s_ready[b] !== 1'b1) begin failures++; $display("FAIL reset_s_ready b=%0d got=%b exp=1", b, s_ready[b]); end
    checks++; if (m_bundle(b) !== '0) begin failures++; $display("FAIL reset_payload b=%0d got=%h exp=0", b, m_bundle(b)); end
    checks++; if (fwd_en[b] !== 1'b0 || load_use[b] !== 1'b0) begin failures++; $display("FAIL reset_fwd b=%0d fwd_en=%b load_use=%b exp=0/0", b, fwd_en[b], load_use[b]); end
    // Asynchronous reset while a bundle is held.
    m_ready[b] = 1'b0;
    set_in(b, 1'b1, mk(32'hDEAD_BEEF, 5'b10000, 5'd3, 32'h40));
    step();
    set_in(b, 1'b0, '0);
    checks++; if (m_valid[b] !== 1'b1 || m_aluout[b] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pre_reset_load b=%0d valid=%b alu=%h exp=1/deadbeef", b, m_valid[b], m_aluout[b]); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (m_valid[b] !== 1'b0 || s_ready[b] !== 1'b1 || m_aluout[b] !== 32'h0) begin
      failures++; $display("FAIL async_reset b=%0d valid=%b ready=%b alu=%h exp=0/1/0", b, m_valid[b], s_ready[b], m_aluout[b]);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_streaming(input int b);
    m_ready[b] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_in(b, 1'b1, mk(i, 5'b10000, 5'd1, 32'h0));
      #1;
      checks++; if (s_ready[b] !== 1'b1) begin failures++; $display("FAIL stream_ready b=%0d i=%0d got=%b exp=1", b, i, s_ready[b]); end
      step();
      checks++; if (m_valid[b] !== 1'b1 || m_aluout[b] !== i) begin failures++; $display("FAIL stream_data b=%0d valid=%b alu=%0d exp=1/%0d", b, m_valid[b], m_aluout[b], i); end
    end
    set_in(b, 1'b0, '0);
    step();
    checks++; if (m_valid[b] !== 1'b0) begin failures++; $display("FAIL stream_drain b=%0d got=%b exp=0", b, m_valid[b]); end
  endtask

  task automatic test_stall(input int b);
    logic [BW-1:0] a, bb;
    a  = mk(32'hA, 5'b10000, 5'd2, 32'h10);
    bb = mk(32'hB, 5'b10000, 5'd4, 32'h20);
    m_ready[b] = 1'b0;
    set_in(b, 1'b1, a);
    step();
    set_in(b, 1'b1, bb);
    #1;
    checks++; if (s_ready[b] !== (b == 0)) begin failures++; $display("FAIL stall_ready_main b=%0d got=%b exp=%b", b, s_ready[b], b == 0); end
    step();
    if (b == 0) set_in(b, 1'b0, '0);
    #1;
    checks++; if (m_bundle(b) !== a || m_valid[b] !== 1'b1) begin failures++; $display("FAIL stall_hold b=%0d got=%h exp=%h", b, m_bundle(b), a); end
    if (b == 0) begin
      checks++; if (s_ready[b] !== 1'b0 || dbg_state[b] !== ST_FULL) begin failures++; $display("FAIL stall_full b=%0d ready=%b state=%0d exp=0/2", b, s_ready[b], dbg_state[b]); end
    end
    m_ready[b] = 1'b1;
    #1;
    checks++; if (s_ready[b] !== (b == 1)) begin failures++; $display("FAIL stall_ready_release b=%0d got=%b exp=%b", b, s_ready[b], b == 1); end
    step();
    set_in(b, 1'b0, '0);
    checks++; if (m_valid[b] !== 1'b1 || m_bundle(b) !== bb) begin failures++; $display("FAIL stall_second b=%0d got=%h exp=%h", b, m_bundle(b), bb); end
    step();
    checks++; if (m_valid[b] !== 1'b0) begin failures++; $display("FAIL stall_no_dup b=%0d got=%b exp=0", b, m_valid[b]); end
  endtask

  task automatic test_flush();
    m_ready[0] = 1'b0;
    set_in(0, 1'b1, mk(32'h1, 5'b10000, 5'd1, 32'h0));
    step();
    set_in(0, 1'b1, mk(32'h2, 5'b10000, 5'd1, 32'h0));
    step();
    set_in(0, 1'b1, mk(32'h3, 5'b10000, 5'd1, 32'h0));
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    set_in(0, 1'b0, '0);
    checks++; if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b1) begin failures++; $display("FAIL flush_full valid=%b ready=%b exp=0/1", m_valid[0], s_ready[0]); end
    m_ready[0] = 1'b1;
    step();
    checks++; if (m_valid[0] !== 1'b0) begin failures++; $display("FAIL flush_dropped valid=%b exp=0", m_valid[0]); end
  endtask

  task automatic test_forwarding();
    m_ready[0] = 1'b0;
    set_in(0, 1'b1, mk(32'hABCD, 5'b11000, 5'd5, 32'h104));
    step();
    set_in(0, 1'b0, '0);
    checks++; if (fwd_en[0] !== 1'b1 || fwd_data[0] !== 32'h104 || fwd_rd_addr[0] !== 5'd5) begin
      failures++; $display("FAIL fwd_link en=%b data=%h rd=%0d exp=1/104/5", fwd_en[0], fwd_data[0], fwd_rd_addr[0]);
    end
    m_ready[0] = 1'b1;
    set_in(0, 1'b1, mk(32'hABCD, 5'b11000, 5'd0, 32'h104));
    step();
    checks++; if (fwd_en[0] !== 1'b0 || m_ctrl[0] !== 5'b11000 || m_rd_addr[0] !== 5'd0) begin
      failures++; $display("FAIL fwd_x0 en=%b ctrl=%b rd=%0d exp=0/11000/0", fwd_en[0], m_ctrl[0], m_rd_addr[0]);
    end
    set_in(0, 1'b1, mk(32'h1234, 5'b10000, 5'd9, 32'h104));
    step();
    checks++; if (fwd_en[0] !== 1'b1 || fwd_data[0] !== 32'h1234) begin failures++; $display("FAIL fwd_alu en=%b data=%h exp=1/1234", fwd_en[0], fwd_data[0]); end
    set_in(0, 1'b1, mk(32'h2000, 5'b10110, 5'd7, 32'h0));
    step();
    set_in(0, 1'b0, '0);
    checks++; if (load_use[0] !== 1'b1 || fwd_en[0] !== 1'b0) begin failures++; $display("FAIL load_use lu=%b fwd_en=%b exp=1/0", load_use[0], fwd_en[0]); end
    step();
    checks++; if (load_use[0] !== 1'b0) begin failures++; $display("FAIL load_use_clear lu=%b exp=0", load_use[0]); end
  endtask

  // Reference: the stage is an in-order queue of depth 2 (skid) or 1 (no skid).
  task automatic test_random(input int b);
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] bun, f;
    logic          v, exp_ready, in_fire, out_fire;
    logic          e_fwd, e_lu;
    logic [31:0]   e_data;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      bun = mk($urandom, 5'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
      set_in(b, v, bun);
      m_ready[b] = ($urandom_range(0, 9) < 6);
      flush[b]   = ($urandom_range(0, 19) == 0);
      #1;
      exp_ready = (b == 0) ? (exp_q.size() < 2) : (exp_q.size() == 0 || m_ready[b]);
      checks++; if (m_valid[b] !== (exp_q.size() > 0)) begin failures++; $display("FAIL rand_valid b=%0d n=%0d got=%b exp=%b", b, n, m_valid[b], exp_q.size() > 0); end
      checks++; if (s_ready[b] !== exp_ready) begin failures++; $display("FAIL rand_ready b=%0d n=%0d got=%b exp=%b", b, n, s_ready[b], exp_ready); end
      if (exp_q.size() > 0) begin
        f = exp_q[0];
        e_fwd  = f[4] && (f[9:5] != 0) && !f[2];
        e_lu   = f[2] && (f[9:5] != 0);
        e_data = f[3] ? f[41:10] : f[105:74];
        checks++; if (m_bundle(b) !== f) begin failures++; $display("FAIL rand_bundle b=%0d n=%0d got=%h exp=%h", b, n, m_bundle(b), f); end
        checks++; if (fwd_en[b] !== e_fwd || load_use[b] !== e_lu || fwd_data[b] !== e_data) begin
          failures++; $display("FAIL rand_fwd b=%0d n=%0d en=%b lu=%b data=%h exp=%b/%b/%h", b, n, fwd_en[b], load_use[b], fwd_data[b], e_fwd, e_lu, e_data);
        end
      end
      in_fire  = v && exp_ready;
      out_fire = (exp_q.size() > 0) && m_ready[b];
      if (out_fire) void'(exp_q.pop_front());
      if (flush[b]) exp_q.delete();
      else if (in_fire) exp_q.push_back(bun);
      step();
    end
    idle_all();
  endtask

  initial begin
    rstn = 1'b0;
    idle_all();
    for (int b = 0; b < 2; b++) test_reset(b);
    for (int b = 0; b < 2; b++) test_streaming(b);
    for (int b = 0; b < 2; b++) begin
      do_reset();
      test_stall(b);
    end
    do_reset();
    test_flush();
    do_reset();
    test_forwarding();
    for (int b = 0; b < 2; b++) test_random(b);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
